// File: rtl/nn_polar_stream_decoder_if.sv
// rtl/nn_polar_stream_decoder_if.sv - stream-side bundle for the polar stochastic decoder
interface nn_polar_stream_decoder_if #(
    parameter int OUT_W = 10
);
    logic             START;
    logic             CONT;
    logic             EN;
    logic             IN_POS;
    logic             IN_NEG;
    logic             BUSY;
    logic             VALID;
    logic [OUT_W-1:0] VALUE;
    logic             SIGN;
    logic [OUT_W-2:0] MAG;

    modport master (
        output START, CONT, EN, IN_POS, IN_NEG,
        input  BUSY, VALID, VALUE, SIGN, MAG
    );

    modport slave (
        input  START, CONT, EN, IN_POS, IN_NEG,
        output BUSY, VALID, VALUE, SIGN, MAG
    );
endinterface

// File: rtl/nn_polar_stream_decoder.sv
// rtl/nn_polar_stream_decoder.sv - integrates a sign-split stochastic stream pair into a signed count
module nn_polar_stream_decoder #(
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = WIN_LOG2 + 2
) (
    input  logic                     CLK,
    input  logic                     INIT,
    nn_polar_stream_decoder_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [OUT_W-1:0]    ACC_ONE  = 1;
    localparam logic [OUT_W-2:0]    MAG_ONE  = 1;
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = 1;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    state_t              state_q, state_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]    value_q, value_d;
    logic [OUT_W-2:0]    mag_q, mag_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    sum;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        mag_d   = mag_q;
        valid_d = 1'b0;

        // Both paths firing cancel, so only exclusive bits move the sum.
        sum = acc_q;
        if (bus.IN_POS && !bus.IN_NEG) begin
            sum = acc_q + ACC_ONE;
        end else if (!bus.IN_POS && bus.IN_NEG) begin
            sum = acc_q - ACC_ONE;
        end

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (bus.EN) begin
                    if (cnt_q == CNT_LAST) begin
                        value_d = sum;
                        // Low-bit negation is exact here, including for -2^WIN_LOG2.
                        mag_d   = sum[OUT_W-1] ? (~sum[OUT_W-2:0] + MAG_ONE) : sum[OUT_W-2:0];
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = bus.CONT ? ACCUM : IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            mag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            mag_q   <= mag_d;
            valid_q <= valid_d;
        end
    end

    assign bus.BUSY  = (state_q == ACCUM);
    assign bus.VALID = valid_q;
    assign bus.VALUE = value_q;
    assign bus.SIGN  = value_q[OUT_W-1];
    assign bus.MAG   = mag_q;
endmodule

// File: tb/tb_nn_polar_stream_decoder.sv
// tb/tb_nn_polar_stream_decoder.sv - scoreboard bench for nn_polar_stream_decoder at WIN_LOG2=4
module tb_nn_polar_stream_decoder;
    logic clk = 1'b0;
    logic init_n;

    nn_polar_stream_decoder_if #(.OUT_W(6)) bus ();

    nn_polar_stream_decoder #(.WIN_LOG2(4), .OUT_W(6)) dut (
        .CLK  (clk),
        .INIT (init_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] value;
        logic [4:0] mag;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_asserts = 0;
    int   n_fail    = 0;
    logic exp_v;
    logic exp_busy;

    task automatic drive(input logic s, input logic ct, input logic en, input logic p, input logic n);
        bus.START  = s;
        bus.CONT   = ct;
        bus.EN     = en;
        bus.IN_POS = p;
        bus.IN_NEG = n;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_asserts++;
        if ({bus.BUSY, bus.VALID, bus.VALUE, bus.SIGN, bus.MAG} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b value=%b sign=%b mag=%0d want all zero",
                     bus.BUSY, bus.VALID, bus.VALUE, bus.SIGN, bus.MAG);
        end
        @(posedge clk);
        #1 init_n = 1'b1;
    endtask

    task automatic test_pos_full;
        sb.push_back('{6'b010000, 5'd16, 17});
        for (int c = 0; c <= 18; c++) begin
            drive(c == 0 || c == 5, 1'b0, c >= 1 && c <= 16, c >= 1 && c <= 16, 1'b0);
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 16);
            n_asserts++;
            if (bus.BUSY !== exp_busy) begin
                n_fail++;
                $display("FAIL pos_full_busy cycle %0d: got %b want %b", c, bus.BUSY, exp_busy);
            end
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL pos_full_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL pos_full_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_cancel;
        sb.push_back('{6'b000000, 5'd0, 17});
        for (int c = 0; c <= 18; c++) begin
            drive(c == 0, 1'b0, c >= 1 && c <= 16, 1'b1, 1'b1);
            @(negedge clk);
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL cancel_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL cancel_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_neg_sparse;
        sb.push_back('{6'b111100, 5'd4, 17});
        for (int c = 0; c <= 18; c++) begin
            drive(c == 0, 1'b0, c >= 1 && c <= 16, 1'b0, c == 2 || c == 5 || c == 9 || c == 16);
            @(negedge clk);
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL neg_sparse_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL neg_sparse_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_en_gated;
        sb.push_back('{6'b010000, 5'd16, 32});
        for (int c = 0; c <= 33; c++) begin
            drive(c == 0, 1'b0, c >= 1 && c <= 31 && (c % 2 == 1), c >= 1 && c <= 31, 1'b0);
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 31);
            n_asserts++;
            if (bus.BUSY !== exp_busy) begin
                n_fail++;
                $display("FAIL en_gated_busy cycle %0d: got %b want %b", c, bus.BUSY, exp_busy);
            end
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL en_gated_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL en_gated_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_init_mid;
        sb.push_back('{6'b110000, 5'd16, 30});
        for (int c = 0; c <= 31; c++) begin
            if (c <= 8)       drive(c == 0, 1'b0, c >= 1, c >= 1, 1'b0);
            else if (c <= 11) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            else              drive(c == 13, 1'b0, c >= 14 && c <= 29, 1'b0, c >= 14 && c <= 29);
            if (c == 8) begin
                init_n = 1'b0;
                #1;
                n_asserts++;
                if ({bus.BUSY, bus.VALID, bus.VALUE, bus.SIGN, bus.MAG} !== 14'd0) begin
                    n_fail++;
                    $display("FAIL init_mid_clear: got busy=%b valid=%b value=%b sign=%b mag=%0d want all zero",
                             bus.BUSY, bus.VALID, bus.VALUE, bus.SIGN, bus.MAG);
                end
            end
            if (c == 12) init_n = 1'b1;
            @(negedge clk);
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL init_mid_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL init_mid_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back;
        sb.push_back('{6'b010000, 5'd16, 17});
        sb.push_back('{6'b001000, 5'd8,  33});
        sb.push_back('{6'b000000, 5'd0,  49});
        for (int c = 0; c <= 51; c++) begin
            drive(c == 0, c < 40, c >= 1, c >= 1 && c <= 24, 1'b0);
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 48);
            n_asserts++;
            if (bus.BUSY !== exp_busy) begin
                n_fail++;
                $display("FAIL back_to_back_busy cycle %0d: got %b want %b", c, bus.BUSY, exp_busy);
            end
            exp_v = (sb.size() != 0) && (sb[0].cyc == c);
            n_asserts++;
            if (bus.VALID !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back_valid cycle %0d: got %b want %b", c, bus.VALID, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                n_asserts++;
                if ({bus.VALUE, bus.SIGN, bus.MAG} !== {e.value, e.value[5], e.mag}) begin
                    n_fail++;
                    $display("FAIL back_to_back_value cycle %0d: got %b/%b/%0d want %b/%b/%0d",
                             c, bus.VALUE, bus.SIGN, bus.MAG, e.value, e.value[5], e.mag);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        init_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_pos_full;
        test_cancel;
        test_neg_sparse;
        test_en_gated;
        test_init_mid;
        test_back_to_back;
        n_asserts++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule

// File: doc/nn_polar_stream_decoder.md
Name: nn_polar_stream_decoder

Overview:
- Converts a polar (sign-split) stochastic bitstream pair, as produced by a polar NN node's positive and negative paths, back into a signed binary value.
- Integrates the net bit count over a fixed window of 2^WIN_LOG2 valid samples and emits the result with a one-cycle valid pulse.
- Sits at the network output and at debug/readout taps, on the receiving end of node streams.

Parameters:
- WIN_LOG2, 8, log2 of window length in valid samples (window = 2^WIN_LOG2).
- OUT_W, WIN_LOG2+2, width of the signed two's-complement result; must be at least WIN_LOG2+2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- INIT  input  1  asynchronous active-low reset.
- START  input  1  starts a window when the block is IDLE; ignored otherwise.
- CONT  input  1  continuous mode; sampled on the final sample of each window.
- EN  input  1  sample qualifier; IN_POS and IN_NEG are counted only in cycles with EN=1.
- IN_POS  input  1  positive stochastic stream.
- IN_NEG  input  1  negative stochastic stream.
- BUSY  output  1  high while state is ACCUM.
- VALID  output  1  one-cycle pulse when VALUE updates.
- VALUE  output  OUT_W  signed net count of the last completed window.
- SIGN  output  1  VALUE[OUT_W-1].
- MAG  output  OUT_W-1  absolute value of VALUE.

Behaviour:
- Reset (INIT=0, asynchronous): state=IDLE; accumulator=0; sample counter=0; BUSY=0, VALID=0, VALUE=0, SIGN=0, MAG=0. Takes effect immediately, including mid-window; the partial window is discarded.
- States: IDLE and ACCUM.
  - IDLE: START=1 → ACCUM next edge, with accumulator and counter cleared. The START cycle itself is not sampled.
  - ACCUM, START: ignored.
- Per-sample delta in ACCUM when EN=1:
  - POS=1, NEG=0 → +1
  - POS=0, NEG=1 → -1
  - POS=1, NEG=1 → 0 (cancellation)
  - POS=0, NEG=0 → 0
  - The sample counter increments on every EN=1 cycle. EN=0 cycles change nothing.
- Final sample is the one where counter = 2^WIN_LOG2-1 and EN=1. On that edge:
  - VALUE <= accumulator + delta.
  - VALID <= 1 for exactly one cycle.
  - Accumulator and counter <= 0.
  - Next state = ACCUM if CONT=1, else IDLE.
- Continuous mode: the next window's first sample may be the very cycle VALID is high, so there is no gap between windows.
- VALUE, SIGN and MAG are registered together. They hold until the next VALID and are unaffected by IDLE, START or EN.
- Range of VALUE is -2^WIN_LOG2 .. +2^WIN_LOG2, so no overflow or saturation is possible at OUT_W ≥ WIN_LOG2+2. MAG of -2^WIN_LOG2 is 2^WIN_LOG2 and is exactly representable.
- Latency: with EN held at 1, VALID is high in cycle S+2^WIN_LOG2+1, where S is the START cycle.
- CONT changing mid-window has no effect until the final sample.

Test Plan (WIN_LOG2=4, OUT_W=6):
- START at cycle 0, EN=1, POS=1, NEG=0 for 16 cycles → VALID only at cycle 17; VALUE=6'b010000 (+16); SIGN=0; MAG=16; BUSY=0 from cycle 17.
- POS=NEG=1 throughout the window → VALUE=0, VALID at cycle 17.
- EN=1, NEG=1 and POS=0 on 4 of 16 samples, else both 0 → VALUE=6'b111100 (-4); SIGN=1; MAG=4.
- EN high only on odd cycles 1..31, POS=1 → VALID at cycle 32; VALUE=+16. POS pulses on EN=0 cycles are not counted.
- INIT low at cycle 8 of a window → all outputs 0 immediately; no VALID. START after release with NEG=1 for 16 samples → VALUE=-16 (6'b110000), MAG=16.
- CONT=1, EN=1, three windows with POS=1 on 16, 8, 0 samples → VALID at cycles 17, 33, 49; VALUE=+16, +8, 0; BUSY stays 1 throughout. CONT=0 before the third window ends → IDLE after cycle 49.
